// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset defaults and
// the PC increment helper used by the IF engine.
package fetch_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_register.sv
// Generic N-bit register with synchronous reset, load enable and flush; both
// reset and flush load RST_VAL.
module register #(
  parameter int           N       = 32,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || flush) q <= RST_VAL;
    else if (en)      q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC, keeps at most one imem request in flight
// and drives the IF/ID register's data, en and flush inputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pcplus4_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            if_id_en_o,
  output logic            if_id_flush_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [XLEN-1:0] buf_q;
  logic            pc_en, buf_en;
  logic            deliver;
  logic [XLEN-1:0] deliver_instr;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            en, flush;

  register #(.N(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(pc_en), .flush(1'b0), .d(pc_d), .q(pc_q)
  );

  register #(.N(XLEN), .RST_VAL(NOP_INSTR)) u_buf (
    .clk(clk), .rst(rst), .en(buf_en), .flush(1'b0), .d(imem_rdata_i), .q(buf_q)
  );

  assign pc_plus4 = pc_inc(pc_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_en         = 1'b0;
    buf_en        = 1'b0;
    req           = 1'b0;
    addr          = pc_q;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    // Default when nothing is handed over: bubble, or hold IF/ID while stalled.
    en            = !stall_i;
    flush         = !stall_i;

    unique case (state_q)
      FETCH: begin
        req     = 1'b1;
        state_d = WAIT;
        if (redirect_i) begin
          addr  = redirect_pc_i;
          pc_d  = redirect_pc_i;
          pc_en = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          pc_en = 1'b1;
          if (imem_rvalid_i) begin
            req     = 1'b1;
            addr    = redirect_pc_i;
            state_d = WAIT;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_rvalid_i) begin
          if (stall_i) begin
            buf_en  = 1'b1;
            state_d = HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata_i;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          req     = 1'b1;
          addr    = redirect_pc_i;
          pc_d    = redirect_pc_i;
          pc_en   = 1'b1;
          state_d = WAIT;
        end else if (!stall_i) begin
          deliver       = 1'b1;
          deliver_instr = buf_q;
        end
      end
      DRAIN: begin
        // The stale response must retire before anything new is requested.
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          pc_en = 1'b1;
        end
        if (imem_rvalid_i) begin
          req     = 1'b1;
          addr    = redirect_i ? redirect_pc_i : pc_q;
          state_d = WAIT;
        end
      end
      default: state_d = FETCH;
    endcase

    if (deliver) begin
      en      = 1'b1;
      flush   = 1'b0;
      req     = 1'b1;
      addr    = pc_plus4;
      pc_d    = pc_plus4;
      pc_en   = 1'b1;
      state_d = WAIT;
    end

    if (redirect_i) begin
      en    = 1'b1;
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    imem_req_o    = req;
    imem_addr_o   = addr;
    if_id_en_o    = en;
    if_id_flush_o = flush;
    if_pc_o       = pc_q;
    if_instr_o    = deliver ? deliver_instr : NOP_INSTR;
    if (rst) begin
      imem_req_o    = 1'b0;
      if_id_en_o    = 1'b0;
      if_id_flush_o = 1'b0;
      if_pc_o       = RESET_PC;
      if_instr_o    = NOP_INSTR;
    end
    if_pcplus4_o = pc_inc(if_pc_o);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an imem model with random latency plus a
// program-order model of what IF/ID must receive each cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] if_pc_o, if_pcplus4_o, if_instr_o;
  logic        if_id_en_o, if_id_flush_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: next PC in program order, the in-flight request, and
  // whether an accepted-but-stalled instruction is parked in the fetch unit.
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  bit          pend, stale, have_buf;
  int          cnt;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_pc_o(if_pc_o),
    .if_pcplus4_o(if_pcplus4_o), .if_instr_o(if_instr_o), .if_id_en_o(if_id_en_o),
    .if_id_flush_o(if_id_flush_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h00A0_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    repeat (3) begin
      #2;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_en", 32'(if_id_en_o), 32'd0);
      chk("rst_flush", 32'(if_id_flush_o), 32'd0);
      chk("rst_pc", if_pc_o, 32'h0);
      chk("rst_instr", if_instr_o, NOP);
      @(negedge clk);
    end
    rst = 1'b0;
    exp_pc = 32'h0;
    pend = 1'b0;
    stale = 1'b0;
    have_buf = 1'b0;
  endtask

  task automatic run(input int n, input int lat_lo, input int lat_hi,
                     input int p_stall, input int p_redir);
    bit          rv, fresh, busy, avail, holding, req_exp;
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      rv = 1'b0;
      if (pend) begin
        cnt--;
        rv = (cnt == 0);
      end
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? memf(pend_addr) : $urandom;
      stall_i       = ($urandom_range(99) < p_stall);
      redirect_i    = ($urandom_range(99) < p_redir);
      case ($urandom_range(3))
        0:       tgt = 32'h0000_0100;
        1:       tgt = 32'hFFFF_FFFC;
        default: tgt = $urandom;
      endcase
      redirect_pc_i = tgt;
      #2;
      fresh = rv && !stale;
      busy  = pend && !rv;
      avail = fresh || have_buf;
      if (redirect_i) begin
        chk("redir_en", 32'(if_id_en_o), 32'd1);
        chk("redir_flush", 32'(if_id_flush_o), 32'd1);
        exp_pc = tgt;
        have_buf = 1'b0;
        if (busy) stale = 1'b1;
      end else if (stall_i) begin
        chk("stall_en", 32'(if_id_en_o), 32'd0);
        chk("stall_flush", 32'(if_id_flush_o), 32'd0);
        if (fresh) have_buf = 1'b1;
      end else if (avail) begin
        chk("dlv_en", 32'(if_id_en_o), 32'd1);
        chk("dlv_flush", 32'(if_id_flush_o), 32'd0);
        chk("dlv_pc", if_pc_o, exp_pc);
        chk("dlv_pcplus4", if_pcplus4_o, exp_pc + 32'd4);
        chk("dlv_instr", if_instr_o, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        have_buf = 1'b0;
      end else begin
        chk("bub_en", 32'(if_id_en_o), 32'd1);
        chk("bub_flush", 32'(if_id_flush_o), 32'd1);
        chk("bub_instr", if_instr_o, NOP);
      end
      holding = avail && stall_i && !redirect_i;
      req_exp = !busy && !holding;
      chk("req", 32'(imem_req_o), 32'(req_exp));
      if (imem_req_o) begin
        chk("req_addr", imem_addr_o, exp_pc);
        pend = 1'b1;
        stale = 1'b0;
        pend_addr = imem_addr_o;
        cnt = int'($urandom_range(lat_hi, lat_lo));
      end else if (rv) begin
        pend = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    exp_pc = '0; pend_addr = '0; pend = 0; stale = 0; have_buf = 0; cnt = 0;
    @(negedge clk);
    do_reset();
    run(12, 1, 1, 0, 0);
    run(24, 3, 3, 0, 0);
    run(400, 1, 3, 25, 8);
    run(5, 3, 3, 0, 0);
    do_reset();
    run(400, 1, 4, 40, 15);
    run(60, 1, 1, 10, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
